// File: rtl/arp_pkg.sv
// Shared ARP definitions: scheduler state encoding, field widths and the
// opcode values used by the TX arbiter and RX parser.
package arp_pkg;

  localparam int IP_W  = 32;
  localparam int MAC_W = 48;

  localparam logic [15:0] ARP_OP_REQUEST = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_REPLY,
    ST_DONE,
    ST_FAIL
  } arp_sched_state_t;

endpackage

// File: rtl/arp_timeout_cnt.sv
// Saturating clear/enable cycle counter; expired is high once the count
// reaches TIMEOUT_CYCLES-1 and stays there until cleared.
module arp_timeout_cnt #(
  parameter longint unsigned TIMEOUT_CYCLES = 2
) (
  input  logic aclk,
  input  logic areset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 64'd1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == LAST);

  always_ff @(posedge aclk) begin
    if (areset || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/arp_rq_sched.sv
// ARP request scheduler: issues ARP requests with timeout/retry and reports the
// resolved MAC or a failure. Optional single-entry cache: ARP_RQ_SCHED_CACHE_EN.
module arp_rq_sched
  import arp_pkg::*;
#(
  parameter int unsigned     TIMEOUT_CYCLES   = 125_000_000,
  parameter int unsigned     MAX_RETRY        = 3,
  parameter longint unsigned CACHE_AGE_CYCLES = 64'hFFFF_FFFF
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             resolve_req,
  input  logic [IP_W-1:0]  resolve_ip,
  output logic             resolve_busy,
  output logic             resolve_done,
  output logic             resolve_fail,
  output logic [MAC_W-1:0] resolve_mac,
  output logic             arp_rq_start,
  output logic [IP_W-1:0]  arp_rq_tip,
  input  logic             arp_tx_done,
  input  logic             arp_reply_valid,
  input  logic [IP_W-1:0]  arp_reply_sip,
  input  logic [MAC_W-1:0] arp_reply_sha
);

  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  arp_sched_state_t state;
  logic [IP_W-1:0]  ip_q;
  logic [RW-1:0]    retry_q;
  logic             reply_seen;
  logic             match;
  logic             to_expired;
  logic             cache_hit;

  assign match      = arp_reply_valid && (arp_reply_sip == ip_q);
  assign arp_rq_tip = ip_q;

  // Held clear outside WAIT_REPLY so every wait window starts from zero.
  arp_timeout_cnt #(
    .TIMEOUT_CYCLES(64'(TIMEOUT_CYCLES))
  ) u_reply_to (
    .aclk    (aclk),
    .areset  (areset),
    .clr     (state != ST_WAIT_REPLY),
    .en      (state == ST_WAIT_REPLY),
    .expired (to_expired)
  );

`ifdef ARP_RQ_SCHED_CACHE_EN
  logic [IP_W-1:0]  cache_ip;
  logic [MAC_W-1:0] cache_mac;
  logic             cache_valid;
  logic             from_cache;
  logic             cache_wr;
  logic             age_expired;

  assign cache_hit = cache_valid && (cache_ip == resolve_ip);
  assign cache_wr  = (state == ST_DONE) && !from_cache;

  arp_timeout_cnt #(
    .TIMEOUT_CYCLES(CACHE_AGE_CYCLES)
  ) u_cache_age (
    .aclk    (aclk),
    .areset  (areset),
    .clr     (cache_wr),
    .en      (cache_valid),
    .expired (age_expired)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      cache_ip    <= '0;
      cache_mac   <= '0;
      cache_valid <= 1'b0;
      from_cache  <= 1'b0;
    end else begin
      if (state == ST_IDLE && resolve_req) begin
        from_cache <= cache_hit;
      end
      if (cache_wr) begin
        cache_ip    <= ip_q;
        cache_mac   <= resolve_mac;
        cache_valid <= 1'b1;
      end else if ((state == ST_FAIL && cache_ip == ip_q) || age_expired) begin
        cache_valid <= 1'b0;
      end
    end
  end
`else
  logic cache_age_unused;

  assign cache_hit        = 1'b0;
  assign cache_age_unused = (CACHE_AGE_CYCLES != 64'd0);
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      state        <= ST_IDLE;
      ip_q         <= '0;
      retry_q      <= '0;
      reply_seen   <= 1'b0;
      resolve_busy <= 1'b0;
      resolve_done <= 1'b0;
      resolve_fail <= 1'b0;
      resolve_mac  <= '0;
      arp_rq_start <= 1'b0;
    end else begin
      resolve_done <= 1'b0;
      resolve_fail <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (resolve_req) begin
            ip_q         <= resolve_ip;
            retry_q      <= '0;
            reply_seen   <= 1'b0;
            resolve_busy <= 1'b1;
            if (cache_hit) begin
`ifdef ARP_RQ_SCHED_CACHE_EN
              resolve_mac <= cache_mac;
`endif
              resolve_done <= 1'b1;
              state        <= ST_DONE;
            end else begin
              arp_rq_start <= 1'b1;
              state        <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          // A reply can overtake our own tx_done; keep it and finish on tx_done.
          if (match) begin
            reply_seen  <= 1'b1;
            resolve_mac <= arp_reply_sha;
          end
          if (arp_tx_done) begin
            arp_rq_start <= 1'b0;
            if (reply_seen || match) begin
              resolve_done <= 1'b1;
              state        <= ST_DONE;
            end else begin
              state <= ST_WAIT_REPLY;
            end
          end
        end
        ST_WAIT_REPLY: begin
          if (match) begin
            resolve_mac  <= arp_reply_sha;
            resolve_done <= 1'b1;
            state        <= ST_DONE;
          end else if (to_expired) begin
            if (32'(retry_q) < MAX_RETRY) begin
              retry_q      <= retry_q + RW'(1);
              reply_seen   <= 1'b0;
              arp_rq_start <= 1'b1;
              state        <= ST_SEND;
            end else begin
              resolve_done <= 1'b1;
              resolve_fail <= 1'b1;
              resolve_mac  <= '0;
              state        <= ST_FAIL;
            end
          end
        end
        ST_DONE, ST_FAIL: begin
          resolve_busy <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_rq_sched.sv
// Bench for arp_rq_sched: plans each resolve transaction as an event timeline,
// derives expected outputs per clock edge, and compares them every cycle.
module tb_arp_rq_sched;
  import arp_pkg::*;

  localparam int TO     = 16;
  localparam int MR     = 2;
  localparam int NE_MAX = 4096;

  logic             aclk = 1'b0;
  logic             areset;
  logic             resolve_req;
  logic [IP_W-1:0]  resolve_ip;
  logic             resolve_busy;
  logic             resolve_done;
  logic             resolve_fail;
  logic [MAC_W-1:0] resolve_mac;
  logic             arp_rq_start;
  logic [IP_W-1:0]  arp_rq_tip;
  logic             arp_tx_done;
  logic             arp_reply_valid;
  logic [IP_W-1:0]  arp_reply_sip;
  logic [MAC_W-1:0] arp_reply_sha;

  always #5 aclk = ~aclk;

  arp_rq_sched #(
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRY(MR)
  ) dut (
    .aclk            (aclk),
    .areset          (areset),
    .resolve_req     (resolve_req),
    .resolve_ip      (resolve_ip),
    .resolve_busy    (resolve_busy),
    .resolve_done    (resolve_done),
    .resolve_fail    (resolve_fail),
    .resolve_mac     (resolve_mac),
    .arp_rq_start    (arp_rq_start),
    .arp_rq_tip      (arp_rq_tip),
    .arp_tx_done     (arp_tx_done),
    .arp_reply_valid (arp_reply_valid),
    .arp_reply_sip   (arp_reply_sip),
    .arp_reply_sha   (arp_reply_sha)
  );

  // Index e = value sampled at / produced after the e-th rising edge.
  bit        s_rst[NE_MAX], s_req[NE_MAX], s_txd[NE_MAX], s_rv[NE_MAX];
  bit [31:0] s_rip[NE_MAX], s_sip[NE_MAX];
  bit [47:0] s_sha[NE_MAX];
  bit        x_start[NE_MAX], x_busy[NE_MAX], x_done[NE_MAX], x_fail[NE_MAX], x_macchk[NE_MAX];
  bit [31:0] x_tip[NE_MAX];
  bit [47:0] x_mac[NE_MAX];

  int        ne, last_done, nend;
  bit [47:0] last_mac;
  bit        c_valid;
  bit [31:0] c_ip;
  bit [47:0] c_mac;

  int n_checks = 0;
  int n_errors = 0;
  int cur = 0;
  bit run = 1'b0;

  task automatic fill_mac(input int upto);
    for (int e = last_done; e <= upto; e++) begin
      x_macchk[e] = 1'b1;
      x_mac[e]    = last_mac;
    end
  endtask

  task automatic put_reply(input int e, input bit [31:0] ip, input bit [47:0] mac);
    s_rv[e]  = 1'b1;
    s_sip[e] = ip;
    s_sha[e] = mac;
  endtask

  // succ_att: attempt that gets the reply (-1: none); kind 1 = reply during SEND.
  task automatic plan_txn(input int gap, input bit [31:0] ip, input int succ_att, input int kind,
                          input int off, input int dfix, input bit noise, input bit spur,
                          input int abort_off);
    int n0, n, t, d, dn, ae, rm, end_e, s;
    bit ok, hit;
    bit [47:0] mac;
    n0  = ne + gap;
    n   = n0;
    dn  = 0; ae = 0; rm = 0; ok = 1'b0; hit = 1'b0;
    mac = {16'($urandom), 32'($urandom)};
    fill_mac(n0 - 1);
    s_req[n0] = 1'b1;
    s_rip[n0] = ip;
`ifdef ARP_RQ_SCHED_CACHE_EN
    if (c_valid && c_ip == ip) begin
      hit = 1'b1; ok = 1'b1; dn = n0; mac = c_mac;
    end
`endif
    for (int k = 0; k <= MR && dn == 0 && ae == 0; k++) begin
      if (dfix > 0) d = dfix;
      else if (k == succ_att && kind == 1) d = int'($urandom_range(6, 2));
      else d = int'($urandom_range(6, 1));
      t = n + d;
      s_txd[t] = 1'b1;
      for (int e = n; e < t; e++) begin
        x_start[e] = 1'b1;
        x_tip[e]   = ip;
      end
      if (k == succ_att && kind == 1) begin
        rm = n + ((off > 0 && off < d) ? off : int'($urandom_range(d - 1, 1)));
        put_reply(rm, ip, mac);
        dn = t; ok = 1'b1;
      end else if (k == succ_att) begin
        rm = t + ((off > 0) ? off : int'($urandom_range(TO, 1)));
        put_reply(rm, ip, mac);
        dn = rm; ok = 1'b1;
      end else if (k == 0 && abort_off > 0) begin
        ae = t + abort_off;
        s_rst[ae] = 1'b1;
      end else if (k == MR) begin
        dn = t + TO;
      end else begin
        n = t + TO;
      end
    end
    end_e = (ae > 0) ? ae - 1 : dn;
    for (int e = n0; e <= end_e; e++) x_busy[e] = 1'b1;
    if (ae > 0) begin
      last_done = ae; last_mac = '0; c_valid = 1'b0; ne = ae + 1;
    end else begin
      x_done[dn] = 1'b1;
      if (!ok) begin
        x_fail[dn] = 1'b1;
        last_mac = '0;
        if (c_ip == ip) c_valid = 1'b0;
      end else begin
        last_mac = mac;
        if (!hit) begin
          c_valid = 1'b1; c_ip = ip; c_mac = mac;
        end
      end
      last_done = dn;
      ne = dn + 2;
      if (spur) begin
        s = int'($urandom_range(dn + 1, n0 + 1));
        s_req[s] = 1'b1;
        s_rip[s] = ip ^ 32'h1;
      end
    end
    if (noise) begin
      if (rm > n0 && !s_rv[rm - 1]) put_reply(rm - 1, ip ^ 32'h100, {16'($urandom), 32'($urandom)});
      if (end_e > n0) begin
        s = int'($urandom_range(end_e, n0 + 1));
        if (!s_rv[s]) put_reply(s, ip ^ 32'h100, {16'($urandom), 32'($urandom)});
      end
    end
  endtask

  task automatic drive(input int e);
    areset          = s_rst[e];
    resolve_req     = s_req[e];
    resolve_ip      = s_rip[e];
    arp_tx_done     = s_txd[e];
    arp_reply_valid = s_rv[e];
    arp_reply_sip   = s_sip[e];
    arp_reply_sha   = s_sha[e];
  endtask

  task automatic check(input string name, input int e, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, e, act, exp);
    end
  endtask

  // Observations of the two directed opening transactions.
  int        first_rise = -1, first_fall = -1, first_done = -1, fail_edge = -1, t2_rises = 0;
  bit [47:0] first_mac, fail_mac;
  bit        first_fail, prev_start = 1'b0;

  always @(negedge aclk) begin
    if (run) begin
      check("rq_start", cur, 64'(arp_rq_start), 64'(x_start[cur]));
      check("busy",     cur, 64'(resolve_busy), 64'(x_busy[cur]));
      check("done",     cur, 64'(resolve_done), 64'(x_done[cur]));
      check("fail",     cur, 64'(resolve_fail), 64'(x_fail[cur]));
      if (x_start[cur])  check("rq_tip", cur, 64'(arp_rq_tip), 64'(x_tip[cur]));
      if (x_macchk[cur]) check("mac",    cur, 64'(resolve_mac), 64'(x_mac[cur]));
      if (arp_rq_start && !prev_start) begin
        if (first_rise < 0) first_rise = cur;
        if (cur > 21 && cur <= 82) t2_rises++;
      end
      if (!arp_rq_start && prev_start && first_fall < 0) first_fall = cur;
      if (resolve_done && first_done < 0) begin
        first_done = cur; first_mac = resolve_mac; first_fail = resolve_fail;
      end
      if (resolve_fail && fail_edge < 0) begin
        fail_edge = cur; fail_mac = resolve_mac;
      end
      prev_start = arp_rq_start;
      if (cur == nend - 1) begin
        check("t1_start_rise",  cur, 64'(first_rise), 64'd5);
        check("t1_start_fall",  cur, 64'(first_fall), 64'd10);
        check("t1_done_edge",   cur, 64'(first_done), 64'd20);
        check("t1_mac",         cur, 64'(first_mac), 64'h0200_0000_00AA);
        check("t1_no_fail",     cur, 64'(first_fail), 64'd0);
        check("t2_start_count", cur, 64'(t2_rises), 64'd3);
        check("t2_fail_edge",   cur, 64'(fail_edge), 64'd82);
        check("t2_fail_mac",    cur, 64'(fail_mac), 64'd0);
        check("model_t1_done",  cur, 64'(x_done[20]), 64'd1);
        check("model_t1_fall",  cur, 64'({x_start[9], x_start[10]}), 64'b10);
        check("model_t2_fail",  cur, 64'({x_fail[81], x_fail[82]}), 64'b01);
      end
    end
  end

  initial begin
    bit [31:0] pool[4];
    int succ, kind, abort_off;
    pool = '{32'hC0A8_0101, 32'hC0A8_0102, 32'hC0A8_0103, 32'hC0A8_0104};
    ne = 3; last_done = 0; last_mac = '0; c_valid = 1'b0; c_ip = '0; c_mac = '0;
    for (int e = 0; e < 3; e++) s_rst[e] = 1'b1;

    plan_txn(2, 32'hC0A8_010A, 0, 0, 10, 5, 1'b0, 1'b0, 0);
    s_sha[20] = 48'h0200_0000_00AA;
    last_mac  = 48'h0200_0000_00AA;
    c_mac     = 48'h0200_0000_00AA;
    plan_txn(3, 32'hC0A8_0114, -1, 0, 0, 3, 1'b0, 1'b0, 0);
    plan_txn(2, 32'h0A00_0001, 0, 0, 6, 0, 1'b1, 1'b0, 0);
    plan_txn(2, 32'h0A00_0002, 0, 0, TO, 0, 1'b0, 1'b0, 0);
    plan_txn(2, 32'h0A00_0003, 0, 1, 2, 5, 1'b0, 1'b1, 0);
    plan_txn(2, 32'h0A00_0004, 1, 0, 0, 0, 1'b0, 1'b0, 0);
    plan_txn(2, 32'h0A00_0004, 0, 0, 0, 0, 1'b0, 1'b0, 0);
    plan_txn(2, 32'h0A00_0005, -1, 0, 0, 0, 1'b0, 1'b0, 7);
    for (int i = 0; i < 40 && ne < NE_MAX - 200; i++) begin
      succ      = int'($urandom_range(MR + 1, 0));
      if (succ == MR + 1) succ = -1;
      kind      = (succ >= 0) ? int'($urandom_range(1, 0)) : 0;
      abort_off = ($urandom_range(7, 0) == 0) ? int'($urandom_range(TO - 1, 1)) : 0;
      if (abort_off > 0) succ = -1;
      plan_txn(int'($urandom_range(5, 0)), pool[$urandom_range(3, 0)], succ, kind, 0, 0,
               1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), abort_off);
    end
    fill_mac(ne + 4);
    nend = ne + 5;

    drive(0);
    for (int e = 0; e < nend; e++) begin
      @(posedge aclk);
      #1;
      cur = e;
      run = 1'b1;
      if (e + 1 < nend) drive(e + 1);
    end
    @(negedge aclk);
    #1;
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
